// File: rtl/cpu_mem_arbiter.sv
// Shares one single-ported, fixed-latency memory between the CPU instruction
// and data ports. Each access is sequenced IDLE -> ISSUE -> (WAIT) -> DONE.
module cpu_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_enable,
  input  logic [ADDR_W-1:0] IM_address,
  output logic [DATA_W-1:0] IM_out,
  output logic              IM_valid,
  input  logic              DM_enable,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              DM_valid,
  output logic              stall,
  output logic              MEM_enable,
  output logic              MEM_write,
  output logic [ADDR_W-1:0] MEM_address,
  output logic [DATA_W-1:0] MEM_in,
  input  logic [DATA_W-1:0] MEM_out
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("cpu_mem_arbiter: MEM_LATENCY must be within 1..15");
  end
  if (ARB_MODE < 0 || ARB_MODE > 2) begin : g_bad_mode
    $error("cpu_mem_arbiter: ARB_MODE must be 0, 1 or 2");
  end

  localparam logic [3:0] LAT4 = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_dm_q, grant_dm_d;
  logic              last_dm_q, last_dm_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] im_out_q, im_out_d;
  logic [DATA_W-1:0] dm_out_q, dm_out_d;
  logic              pick_dm;

  // A lone requester always wins; a tie is resolved by ARB_MODE.
  always_comb begin
    pick_dm = DM_enable;
    if (IM_enable && DM_enable) begin
      if (ARB_MODE == 1)      pick_dm = 1'b1;
      else if (ARB_MODE == 2) pick_dm = 1'b0;
      else                    pick_dm = ~last_dm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_dm_q <= 1'b0;
      last_dm_q  <= 1'b1;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      im_out_q   <= '0;
      dm_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_dm_q <= grant_dm_d;
      last_dm_q  <= last_dm_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      im_out_q   <= im_out_d;
      dm_out_q   <= dm_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_dm_d = grant_dm_q;
    last_dm_d  = last_dm_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    im_out_d   = im_out_q;
    dm_out_d   = dm_out_q;
    unique case (state_q)
      S_IDLE: begin
        if (IM_enable || DM_enable) begin
          grant_dm_d = pick_dm;
          last_dm_d  = pick_dm;
          write_d    = pick_dm & DM_write;
          addr_d     = pick_dm ? DM_address : IM_address;
          if (pick_dm) wdata_d = DM_in;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT4;
        state_d = write_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        // Count 1 marks the cycle in which MEM_out carries the read data.
        if (cnt_q == 4'd1) begin
          if (grant_dm_q) dm_out_d = MEM_out;
          else            im_out_d = MEM_out;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_enable = (state_q == S_ISSUE);
    MEM_write  = MEM_enable & write_q;
    IM_valid   = (state_q == S_DONE) & ~grant_dm_q;
    DM_valid   = (state_q == S_DONE) & grant_dm_q;
    stall      = (IM_enable & ~IM_valid) | (DM_enable & ~DM_valid);
  end

  assign MEM_address = addr_q;
  assign MEM_in      = wdata_q;
  assign IM_out      = im_out_q;
  assign DM_out      = dm_out_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: three instances (latency 1/3/15, arbitration
// modes 0/1/2), each backed by a behavioural fixed-latency memory.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst, im_en, dm_en, dm_wr;
  logic [2:0][31:0]  im_addr, dm_addr, dm_din;
  logic [2:0][31:0]  im_out, dm_out, mem_addr, mem_din, mem_rd;
  logic [2:0]        im_valid, dm_valid, stall, mem_en, mem_wr;

  // Environment memory: written cells are kept here, unwritten cells read init_word.
  logic [31:0] mem     [3][256];
  bit          mem_vld [3][256];
  logic [31:0] ref_mem [3][256];
  int          ret_cnt   [3] = '{0, 0, 0};
  logic [31:0] ret_data  [3] = '{32'h0, 32'h0, 32'h0};
  int          men_count [3] = '{0, 0, 0};
  logic [31:0] last_iss  [3] = '{32'h0, 32'h0, 32'h0};

  int nvec = 0;
  int nerr = 0;
  bit mon_on = 1'b0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 15;
  endfunction

  function automatic logic [31:0] init_word(input int d, input logic [7:0] a);
    if (d == 0 && a == 8'h00) return 32'h0000_0013;
    return 32'hA5A5_A500 | {24'h0, a};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    cpu_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(lat_of(gi)), .ARB_MODE(gi)
    ) u_dut (
      .clk(clk), .rst(rst[gi]),
      .IM_enable(im_en[gi]), .IM_address(im_addr[gi]), .IM_out(im_out[gi]), .IM_valid(im_valid[gi]),
      .DM_enable(dm_en[gi]), .DM_write(dm_wr[gi]), .DM_address(dm_addr[gi]), .DM_in(dm_din[gi]),
      .DM_out(dm_out[gi]), .DM_valid(dm_valid[gi]), .stall(stall[gi]),
      .MEM_enable(mem_en[gi]), .MEM_write(mem_wr[gi]), .MEM_address(mem_addr[gi]),
      .MEM_in(mem_din[gi]), .MEM_out(mem_rd[gi])
    );

    // Read data is only presented in the cycle it is due; otherwise its complement.
    assign mem_rd[gi] = (ret_cnt[gi] == 1) ? ret_data[gi] : ~ret_data[gi];

    always @(posedge clk) begin
      if (ret_cnt[gi] != 0) ret_cnt[gi] <= ret_cnt[gi] - 1;
      if (mem_en[gi] === 1'b1) begin
        men_count[gi] <= men_count[gi] + 1;
        last_iss[gi]  <= mem_addr[gi];
        if (mem_wr[gi]) begin
          mem[gi][mem_addr[gi][7:0]]     <= mem_din[gi];
          mem_vld[gi][mem_addr[gi][7:0]] <= 1'b1;
        end else begin
          ret_cnt[gi]  <= lat_of(gi);
          ret_data[gi] <= mem_vld[gi][mem_addr[gi][7:0]] ? mem[gi][mem_addr[gi][7:0]]
                                                         : init_word(gi, mem_addr[gi][7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 3; d++)
        chk($sformatf("stall_dut%0d", d), 32'(stall[d]),
            32'((im_en[d] & ~im_valid[d]) | (dm_en[d] & ~dm_valid[d])));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 3'b111; im_en = '0; dm_en = '0; dm_wr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 3'b000;
  endtask

  // Starts a request at phase #1 of a cycle and waits for its valid pulse.
  task automatic do_access(input int d, input bit is_dm, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat,
                           output int npulse, output logic [31:0] iss);
    int c0;
    c0  = men_count[d];
    lat = -1;
    if (is_dm) begin
      dm_addr[d] = addr; dm_din[d] = wd; dm_wr[d] = wr; dm_en[d] = 1'b1;
    end else begin
      im_addr[d] = addr; im_en[d] = 1'b1;
    end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (is_dm ? dm_valid[d] : im_valid[d]) begin
        lat = k;
        break;
      end
    end
    rd = is_dm ? dm_out[d] : im_out[d];
    if (is_dm && wr) ref_mem[d][addr[7:0]] = wd;
    im_en[d] = 1'b0; dm_en[d] = 1'b0; dm_wr[d] = 1'b0;
    npulse = men_count[d] - c0;
    iss    = last_iss[d];
    @(posedge clk); #1;
  endtask

  // Both ports request; each port performs two reads, dropping its request after the second.
  task automatic run_arb(input int d, input logic [3:0] order);
    int got, im_left, dm_left;
    got = 0; im_left = 2; dm_left = 2;
    im_addr[d] = 32'h20; dm_addr[d] = 32'h60; dm_wr[d] = 1'b0;
    im_en[d] = 1'b1; dm_en[d] = 1'b1;
    for (int k = 0; k < 200 && got < 4; k++) begin
      @(posedge clk); #1;
      if (im_valid[d] || dm_valid[d]) begin
        chk($sformatf("arb_dut%0d_order%0d", d, got), 32'(dm_valid[d]), 32'(order[got]));
        $display("arb dut%0d grant%0d %s", d, got, dm_valid[d] ? "DM" : "IM");
        if (dm_valid[d]) begin
          chk($sformatf("arb_dut%0d_dm_data", d), dm_out[d], ref_mem[d][dm_addr[d][7:0]]);
          dm_addr[d] += 4; dm_left--;
          if (dm_left == 0) dm_en[d] = 1'b0;
        end else begin
          chk($sformatf("arb_dut%0d_im_data", d), im_out[d], ref_mem[d][im_addr[d][7:0]]);
          im_addr[d] += 4; im_left--;
          if (im_left == 0) im_en[d] = 1'b0;
        end
        got++;
      end
    end
    chk($sformatf("arb_dut%0d_count", d), 32'(got), 32'd4);
    im_en[d] = 1'b0; dm_en[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          d;
    bit          is_dm;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [31:0] rd, ia;
    int lat, np, c0, got;
    bit seen;

    tbl[0] = '{0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0013, 3};
    tbl[1] = '{1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 2};
    tbl[2] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 5};
    tbl[3] = '{2, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A504, 17};
    tbl[4] = '{2, 1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, 32'h0000_0000, 2};
    tbl[5] = '{2, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h1234_5678, 17};
    tbl[6] = '{0, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 2};
    tbl[7] = '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 3};
    tbl[8] = '{1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hA5A5_A520, 5};

    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++) ref_mem[d][a] = init_word(d, 8'(a));

    im_addr = '0; dm_addr = '0; dm_din = '0;
    rst = 3'b111; im_en = '0; dm_en = '0; dm_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_dut%0d_im_out", d), im_out[d], 32'h0);
      chk($sformatf("rst_dut%0d_dm_out", d), dm_out[d], 32'h0);
      chk($sformatf("rst_dut%0d_mem_addr", d), mem_addr[d], 32'h0);
      chk($sformatf("rst_dut%0d_mem_in", d), mem_din[d], 32'h0);
      chk($sformatf("rst_dut%0d_strobes", d),
          32'({mem_en[d], mem_wr[d], im_valid[d], dm_valid[d], stall[d]}), 32'h0);
    end
    rst = 3'b000;
    mon_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i].d, tbl[i].is_dm, tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, lat, np, ia);
      $display("vec %0d dut%0d %s %s addr=%h data=%h lat=%0d", i, tbl[i].d,
               tbl[i].is_dm ? "DM" : "IM", tbl[i].wr ? "wr" : "rd", tbl[i].addr, rd, lat);
      chk($sformatf("vec%0d_data", i), rd, tbl[i].exp_data);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_mem_pulses", i), 32'(np), 32'd1);
      chk($sformatf("vec%0d_mem_addr", i), ia, tbl[i].addr);
    end

    // IM request held across DONE while the address advances.
    c0 = men_count[0]; got = 0;
    im_addr[0] = 32'h30; im_en[0] = 1'b1;
    for (int k = 0; k < 100 && got < 3; k++) begin
      @(posedge clk); #1;
      if (im_valid[0]) begin
        chk($sformatf("held%0d_data", got), im_out[0], ref_mem[0][im_addr[0][7:0]]);
        chk($sformatf("held%0d_issue_addr", got), last_iss[0], im_addr[0]);
        $display("held fetch %0d addr=%h data=%h", got, im_addr[0], im_out[0]);
        got++;
        im_addr[0] += 4;
        if (got == 3) im_en[0] = 1'b0;
      end
    end
    im_en[0] = 1'b0;
    chk("held_completions", 32'(got), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("held_mem_pulses", 32'(men_count[0] - c0), 32'd3);

    do_reset();
    run_arb(0, 4'b1010);
    run_arb(1, 4'b0011);
    run_arb(2, 4'b1100);

    // Reset while the dut1 read sits in WAIT.
    im_addr[1] = 32'h24; im_en[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_en[1]) break;
    end
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_im_out", im_out[1], 32'h0);
    chk("rstwait_dm_out", dm_out[1], 32'h0);
    chk("rstwait_mem_addr", mem_addr[1], 32'h0);
    chk("rstwait_mem_in", mem_din[1], 32'h0);
    chk("rstwait_strobes", 32'({mem_en[1], mem_wr[1], im_valid[1], dm_valid[1]}), 32'h0);
    rst[1] = 1'b0; im_en[1] = 1'b0;
    c0 = men_count[1]; seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (im_valid[1] || dm_valid[1]) seen = 1'b1;
    end
    chk("rstwait_no_valid", 32'(seen), 32'd0);
    chk("rstwait_no_issue", 32'(men_count[1] - c0), 32'd0);
    do_access(1, 1'b0, 1'b0, 32'h28, 32'h0, rd, lat, np, ia);
    $display("post-reset fetch addr=%h data=%h lat=%0d", 32'h28, rd, lat);
    chk("rstwait_fresh_data", rd, ref_mem[1][8'h28]);
    chk("rstwait_fresh_latency", 32'(lat), 32'd5);

    // Random IM/DM mix on the latency-15 instance.
    c0 = men_count[2];
    fork
      begin
        logic [7:0] idx; logic [31:0] a; int k;
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          idx = {1'b0, 5'($urandom_range(0, 31)), 2'b00};
          a = {24'($urandom), idx};
          im_addr[2] = a; im_en[2] = 1'b1;
          for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (im_valid[2]) break;
          end
          chk("rand_im_timeout", 32'(k > 200), 32'd0);
          chk("rand_im_data", im_out[2], ref_mem[2][idx]);
          $display("rand IM %0d addr=%h data=%h cycles=%0d", i, a, im_out[2], k);
          im_en[2] = 1'b0;
        end
      end
      begin
        logic [7:0] idx; logic [31:0] a, wd, prev; bit w; int k;
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          idx = {1'b1, 5'($urandom_range(0, 31)), 2'b00};
          a = {24'($urandom), idx};
          w = 1'($urandom_range(0, 1));
          wd = $urandom;
          prev = dm_out[2];
          dm_addr[2] = a; dm_din[2] = wd; dm_wr[2] = w; dm_en[2] = 1'b1;
          for (k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (dm_valid[2]) break;
          end
          chk("rand_dm_timeout", 32'(k > 200), 32'd0);
          if (w) begin
            chk("rand_wr_dm_out_kept", dm_out[2], prev);
            ref_mem[2][idx] = wd;
          end else begin
            chk("rand_rd_data", dm_out[2], ref_mem[2][idx]);
          end
          $display("rand DM %0d %s addr=%h data=%h cycles=%0d", i, w ? "wr" : "rd", a,
                   w ? wd : dm_out[2], k);
          dm_en[2] = 1'b0; dm_wr[2] = 1'b0;
        end
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rand_mem_pulses", 32'(men_count[2] - c0), 32'd200);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
